mem_access_unit: RTL and testbench

//  CPU-side initiator for the word-addressed unified memory of the multi-cycle MIPS.

---
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   CPU-side initiator for the word-addressed unified memory of the
//   multi-cycle MIPS. It takes byte/half/word load and store requests from the
//   datapath, drives whole-word memory cycles, and returns aligned,
//   sign- or zero-extended load data. Sub-word stores are performed as
//   read-modify-write because the memory only writes whole words.
//
//   State | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a request (req_ready=1)
//   RD    | mem_read held for READ_WAIT+1 cycles, word captured on last
//   WR    | mem_write for one cycle with the (merged) store word
//   DONE  | resp_valid pulse, resp_rdata/resp_err presented
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (accept when both high)
//   req_write, req_size,        request: store flag, size (00 B, 01 H, 10 W),
//   req_unsigned, req_addr,     zero-extend flag, byte address, right-justified
//   req_wdata                   store data
//   resp_valid, resp_rdata,     one-cycle completion pulse with extended load
//   resp_err                    data and error flag
//   mem_read, mem_write,        memory control, word address and write data
//   mem_addr, mem_wdata
//   mem_rdata                   memory read data (combinational while mem_read)

module mem_access_unit #(
    parameter int MEM_WORDS = 4096,
    parameter int READ_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
    localparam logic [3:0]  WAIT_INIT   = 4'(READ_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] word_q;
    logic [3:0]  wait_cnt;
    logic        req_err;

    // Replace only the addressed lane of the old word; a word store replaces all.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offs);
        logic [31:0] r;
        r = old_word;
        case (size)
            2'b00:   r[{offs, 3'b000} +: 8]        = new_data[7:0];
            2'b01:   r[{offs[1], 4'b0000} +: 16]   = new_data[15:0];
            default: r                             = new_data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offs,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{offs, 3'b000} +: 8];
        h = word[{offs[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_err = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                   | ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);

    // Address and write data come straight from held registers, so both keep
    // their value through IDLE and are 0 out of reset.
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = merge_word(word_q, wdata_q, size_q, addr_q[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            word_q     <= '0;
            wait_cnt   <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        wdata_q    <= req_wdata;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        req_ready  <= 1'b0;
                        if (req_err) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && (req_size == 2'b10)) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_read <= 1'b1;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                RD: begin
                    if (wait_cnt == 4'd0) begin
                        word_q   <= mem_rdata;
                        mem_read <= 1'b0;
                        if (write_q) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                        end else begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= extend_load(mem_rdata, size_q, addr_q[1:0], unsigned_q);
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WR: begin
                    state      <= DONE;
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int MEM_WORDS = 4096;
    localparam int RW        = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    mem_access_unit #(.MEM_WORDS(MEM_WORDS), .READ_WAIT(RW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge.
    assign mem_rdata = mem_read ? mem[mem_addr[13:2]] : 32'h0;
    always @(posedge clk) if (mem_write) mem[mem_addr[13:2]] <= mem_wdata;

    always @(negedge clk) begin
        if (mem_read && mem_write) begin
            n_checks++;
            $display("FAIL rd_wr_overlap: mem_read=1 and mem_write=1 together at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural reference: plain arithmetic on the byte address and word array.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic e, output int lat,
                                  output int nrd, output int nwr, output logic [31:0] wdat);
        int unsigned idx, off;
        logic [31:0] word, v, m, sh;
        idx = a / 4;
        off = a % 4;
        e = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0)
            || (idx >= MEM_WORDS);
        rd = 0; wdat = 0; nrd = 0; nwr = 0; lat = 1;
        if (e) return;
        word = ref_mem[idx];
        if (!w) begin
            if (sz == 2'd0) begin
                v = (word >> (8 * off)) & 32'hFF;
                if (!u && v >= 128) v = v - 32'd256;
            end else if (sz == 2'd1) begin
                v = (word >> (16 * (off / 2))) & 32'hFFFF;
                if (!u && v >= 32768) v = v - 32'd65536;
            end else v = word;
            rd = v; lat = 2 + RW; nrd = RW + 1;
        end else begin
            nwr = 1;
            if (sz == 2'd2) begin
                wdat = d; lat = 2;
            end else begin
                m  = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                sh = 8 * off;
                wdat = (word & ~(m << sh)) | ((d & m) << sh);
                lat = 3 + RW; nrd = RW + 1;
            end
            ref_mem[idx] = wdat;
        end
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat,
                          output int nrd, output int nwr,
                          output logic [31:0] waddr, output logic [31:0] wdat);
        int guard;
        bit done;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; done = 0; rd = 'x; e = 1'bx; waddr = 0; wdat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; waddr = mem_addr; wdat = mem_wdata; end
            if (resp_valid) begin done = 1; rd = resp_rdata; e = resp_err; end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL resp_timeout: no resp_valid within %0d cycles, addr %h", lat, a);
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wdat;
    } vec_t;

    initial begin
        vec_t vecs[15];
        logic [31:0] rd, waddr, wdat, m_rd, m_wdat;
        logic e, m_e;
        int lat, nrd, nwr, m_lat, m_nrd, m_nwr, guard, rv_seen;

        for (int i = 0; i < MEM_WORDS; i++) begin mem[i] = 0; ref_mem[i] = 0; end

        vecs[0]  = '{1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF};
        vecs[1]  = '{1, 2'd2, 0, 32'h4,    32'hDEADBEEF, 32'h0,        0, 2, 32'hDEADBEEF};
        vecs[2]  = '{0, 2'd0, 0, 32'h5,    32'h0,        32'hFFFFFFBE, 0, 2, 32'h0};
        vecs[3]  = '{0, 2'd0, 1, 32'h5,    32'h0,        32'h000000BE, 0, 2, 32'h0};
        vecs[4]  = '{0, 2'd1, 0, 32'h6,    32'h0,        32'hFFFFDEAD, 0, 2, 32'h0};
        vecs[5]  = '{1, 2'd1, 0, 32'h6,    32'h1234,     32'h0,        0, 3, 32'h1234BEEF};
        vecs[6]  = '{0, 2'd2, 0, 32'h4,    32'h0,        32'h1234BEEF, 0, 2, 32'h0};
        vecs[7]  = '{0, 2'd1, 0, 32'h7,    32'h0,        32'h0,        1, 1, 32'h0};
        vecs[8]  = '{0, 2'd3, 0, 32'h0,    32'h0,        32'h0,        1, 1, 32'h0};
        vecs[9]  = '{0, 2'd2, 0, 32'h4000, 32'h0,        32'h0,        1, 1, 32'h0};
        vecs[10] = '{0, 2'd2, 0, 32'h3FFC, 32'h0,        32'h0,        0, 2, 32'h0};
        vecs[11] = '{1, 2'd2, 0, 32'h3FFC, 32'hA5A55A5A, 32'h0,        0, 2, 32'hA5A55A5A};
        vecs[12] = '{0, 2'd0, 0, 32'h3FFF, 32'h0,        32'hFFFFFFA5, 0, 2, 32'h0};
        vecs[13] = '{0, 2'd1, 1, 32'h4,    32'h0,        32'h0000BEEF, 0, 2, 32'h0};
        vecs[14] = '{0, 2'd2, 0, 32'h2,    32'h0,        32'h0,        1, 1, 32'h0};

        // Reset, with a request presented that must be ignored.
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hFFFF0000;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {31'h0, req_ready, resp_valid, resp_err, mem_read, mem_write},
              {31'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        check("reset_rdata", resp_rdata, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {30'h0, resp_valid, mem_write}, 32'h0);
        check("ignored_req_mem", mem[4], 32'h0);

        // Directed table.
        foreach (vecs[i]) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d,
                   rd, e, lat, nrd, nwr, waddr, wdat);
            model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d,
                  m_rd, m_e, m_lat, m_nrd, m_nwr, m_wdat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].exp_err) check($sformatf("vec%0d_no_access", i), nrd + nwr, 0);
            if (vecs[i].w && !vecs[i].exp_err) begin
                check($sformatf("vec%0d_wcount", i), nwr, 1);
                check($sformatf("vec%0d_waddr", i), waddr, vecs[i].a & ~32'h3);
                check($sformatf("vec%0d_wdata", i), wdat, vecs[i].exp_wdat);
            end
        end

        // Reset during the WR cycle of a byte store.
        do_req(1, 2'd2, 0, 32'h20, 32'h11223344, rd, e, lat, nrd, nwr, waddr, wdat);
        model(1, 2'd2, 0, 32'h20, 32'h11223344, m_rd, m_e, m_lat, m_nrd, m_nwr, m_wdat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h21; req_wdata = 32'hAB;
        @(posedge clk); #1 req_valid = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!mem_write && guard < 20);
        check("abort_reached_wr", {31'h0, mem_write}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_mem_write_async", {31'h0, mem_write}, 32'h0);
        rv_seen = 0;
        repeat (2) begin @(negedge clk); if (resp_valid) rv_seen++; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (resp_valid) rv_seen++; end
        check("abort_no_resp", rv_seen, 0);
        check("abort_mem_unchanged", mem[8], 32'h11223344);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        do_req(0, 2'd2, 0, 32'h20, 32'h0, rd, e, lat, nrd, nwr, waddr, wdat);
        check("after_abort_load", rd, 32'h11223344);
        check("after_abort_latency", lat, 2);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic w, u;
            logic [1:0] sz;
            logic [31:0] a, d;
            int unsigned idx;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 19))
                0:       idx = MEM_WORDS + $urandom_range(0, 100);
                1:       idx = MEM_WORDS - 1;
                default: idx = $urandom_range(0, 15);
            endcase
            a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) a = a & ~32'h1;
            if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
            d = $urandom;
            do_req(w, sz, u, a, d, rd, e, lat, nrd, nwr, waddr, wdat);
            model(w, sz, u, a, d, m_rd, m_e, m_lat, m_nrd, m_nwr, m_wdat);
            check($sformatf("rand%0d_rdata", n), rd, m_rd);
            check($sformatf("rand%0d_err", n), {31'h0, e}, {31'h0, m_e});
            check($sformatf("rand%0d_latency", n), lat, m_lat);
            check($sformatf("rand%0d_reads", n), nrd, m_nrd);
            check($sformatf("rand%0d_writes", n), nwr, m_nwr);
            if (m_nwr == 1) check($sformatf("rand%0d_wdata", n), wdat, m_wdat);
        end

        for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
        check("final_mem_top", mem[MEM_WORDS-1], ref_mem[MEM_WORDS-1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
